// File: rtl/vend_controller.sv
// Vending machine main controller: coin acceptance, credit accumulation,
// timed item dispense, and change/refund returned as a train of nickel pulses.
module vend_controller #(
    parameter int PRICE       = 13,
    parameter int MAX_CREDIT  = 40,
    parameter int CREDIT_W    = 6,
    parameter int VEND_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_n,
    input  logic                coin_d,
    input  logic                coin_q,
    input  logic                select,
    input  logic                cancel,
    input  logic                stock_empty,
    output logic [2:0]          state,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_CREDIT = 3'b001,
        S_VEND   = 3'b010,
        S_CHANGE = 3'b011,
        S_REFUND = 3'b100
    } state_t;

    // One extra bit so credit + coin value cannot wrap before the limit compare.
    localparam int SUM_W  = CREDIT_W + 1;
    localparam int VCNT_W = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [VCNT_W-1:0]   vend_cnt_q, vend_cnt_d;
    logic                dispense_q, dispense_d;
    logic                change_pulse_q, change_pulse_d;
    logic                coin_reject_q, coin_reject_d;

    logic [1:0]          coin_count;
    logic                coin_any;
    logic [SUM_W-1:0]    coin_val;
    logic [SUM_W-1:0]    credit_sum;
    logic                coin_ok;
    logic                can_vend;

    // Decode the coin inputs and decide whether this cycle's coin is accepted.
    always_comb begin
        coin_count = 2'(coin_n) + 2'(coin_d) + 2'(coin_q);
        coin_any   = coin_n | coin_d | coin_q;
        coin_val   = '0;
        if (coin_n)      coin_val = SUM_W'(1);
        else if (coin_d) coin_val = SUM_W'(2);
        else if (coin_q) coin_val = SUM_W'(5);
        credit_sum = {1'b0, credit_q} + coin_val;
        coin_ok    = ((state_q == S_IDLE) || (state_q == S_CREDIT)) &&
                     (coin_count == 2'd1) && !select && !cancel &&
                     (credit_sum <= SUM_W'(MAX_CREDIT));
        // The price compare guards the subtraction taken on entry to VEND.
        can_vend   = (credit_q >= CREDIT_W'(PRICE)) && !stock_empty;
    end

    // Next-state, next-credit and registered-output logic.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        vend_cnt_d     = vend_cnt_q;
        dispense_d     = 1'b0;
        change_pulse_d = 1'b0;
        coin_reject_d  = coin_any && !coin_ok;
        case (state_q)
            S_IDLE: begin
                if (coin_ok) begin
                    state_d  = S_CREDIT;
                    credit_d = credit_sum[CREDIT_W-1:0];
                end
            end
            S_CREDIT: begin
                if (cancel) begin
                    state_d = S_REFUND;
                end else if (select && can_vend) begin
                    state_d    = S_VEND;
                    credit_d   = credit_q - CREDIT_W'(PRICE);
                    vend_cnt_d = '0;
                    dispense_d = 1'b1;
                end else if (coin_ok) begin
                    credit_d = credit_sum[CREDIT_W-1:0];
                end
            end
            S_VEND: begin
                if (vend_cnt_q == VCNT_W'(VEND_CYCLES - 1)) begin
                    state_d    = (credit_q != '0) ? S_CHANGE : S_IDLE;
                    vend_cnt_d = '0;
                end else begin
                    vend_cnt_d = vend_cnt_q + VCNT_W'(1);
                    dispense_d = 1'b1;
                end
            end
            S_CHANGE, S_REFUND: begin
                if (credit_q != '0) begin
                    credit_d       = credit_q - CREDIT_W'(1);
                    change_pulse_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                // Unused codes recover through REFUND so no credit is kept.
                state_d = S_REFUND;
            end
        endcase
    end

    // State and output registers; reset clears everything without a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            vend_cnt_q     <= '0;
            dispense_q     <= 1'b0;
            change_pulse_q <= 1'b0;
            coin_reject_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            vend_cnt_q     <= vend_cnt_d;
            dispense_q     <= dispense_d;
            change_pulse_q <= change_pulse_d;
            coin_reject_q  <= coin_reject_d;
        end
    end

    assign state        = state_q;
    assign credit       = credit_q;
    assign dispense     = dispense_q;
    assign change_pulse = change_pulse_q;
    assign coin_reject  = coin_reject_q;
    assign busy         = (state_q == S_VEND) || (state_q == S_CHANGE) ||
                          (state_q == S_REFUND);

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios with literal
// expectations plus randomized traffic compared each cycle against a
// behavioural model of the machine.
module tb_vend_controller;

    localparam int PRICE       = 13;
    localparam int MAX_CREDIT  = 40;
    localparam int CREDIT_W    = 6;
    localparam int VEND_CYCLES = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                coin_n = 1'b0, coin_d = 1'b0, coin_q = 1'b0;
    logic                select = 1'b0, cancel = 1'b0, stock_empty = 1'b0;
    logic [2:0]          state;
    logic [CREDIT_W-1:0] credit;
    logic                dispense, change_pulse, coin_reject, busy;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state
    int m_state = 0, m_credit = 0, m_vend_left = 0;
    int m_disp = 0, m_pulse = 0, m_rej = 0;

    vend_controller #(
        .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT),
        .CREDIT_W(CREDIT_W), .VEND_CYCLES(VEND_CYCLES)
    ) dut (
        .clk(clk), .reset(reset),
        .coin_n(coin_n), .coin_d(coin_d), .coin_q(coin_q),
        .select(select), .cancel(cancel), .stock_empty(stock_empty),
        .state(state), .credit(credit), .dispense(dispense),
        .change_pulse(change_pulse), .coin_reject(coin_reject), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_state = 0; m_credit = 0; m_vend_left = 0;
        m_disp = 0; m_pulse = 0; m_rej = 0;
    endtask

    task automatic model_step();
        int  ncoin, val;
        bit  acc;
        ncoin = int'(coin_n) + int'(coin_d) + int'(coin_q);
        val   = coin_n ? 1 : (coin_d ? 2 : 5);
        acc   = (m_state == 0 || m_state == 1) && ncoin == 1 && !select &&
                !cancel && (m_credit + val <= MAX_CREDIT);
        m_rej   = (ncoin > 0 && !acc) ? 1 : 0;
        m_disp  = 0;
        m_pulse = 0;
        case (m_state)
            0: if (acc) begin m_state = 1; m_credit = val; end
            1: begin
                if (cancel) m_state = 4;
                else if (select && m_credit >= PRICE && !stock_empty) begin
                    m_state = 2; m_credit -= PRICE;
                    m_vend_left = VEND_CYCLES; m_disp = 1;
                end else if (acc) m_credit += val;
            end
            2: begin
                m_vend_left--;
                if (m_vend_left == 0) m_state = (m_credit > 0) ? 3 : 0;
                else m_disp = 1;
            end
            3, 4: begin
                if (m_credit > 0) begin m_credit--; m_pulse = 1; end
                else m_state = 0;
            end
            default: m_state = 4;
        endcase
    endtask

    // Model update on every edge (or reset) and full output compare just after.
    always begin
        @(posedge clk or posedge reset);
        if (reset) model_reset();
        else model_step();
        #1;
        chk("model_state", int'(state), m_state);
        chk("model_credit", int'(credit), m_credit);
        chk("model_dispense", int'(dispense), m_disp);
        chk("model_change_pulse", int'(change_pulse), m_pulse);
        chk("model_coin_reject", int'(coin_reject), m_rej);
        chk("model_busy", int'(busy), (m_state >= 2 && m_state <= 4) ? 1 : 0);
    end

    task automatic put(input int kind);
        coin_n = (kind == 1);
        coin_d = (kind == 2);
        coin_q = (kind == 5);
        @(negedge clk);
        coin_n = 1'b0; coin_d = 1'b0; coin_q = 1'b0;
    endtask

    task automatic sel();
        select = 1'b1;
        @(negedge clk);
        select = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
    endtask

    task automatic wait_state(input int code, input int budget, input string name);
        for (int i = 0; i < budget && int'(state) != code; i++) @(negedge clk);
        chk(name, int'(state), code);
    endtask

    task automatic count_pulses(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            if (change_pulse) cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int pc;
        #1 reset = 1'b1;
        #2;
        chk("reset_state", int'(state), 0);
        chk("reset_credit", int'(credit), 0);
        chk("reset_dispense", int'(dispense), 0);
        chk("reset_change_pulse", int'(change_pulse), 0);
        chk("reset_coin_reject", int'(coin_reject), 0);
        chk("reset_busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Purchase with 2 nickels of change
        put(5); put(5); put(5);
        chk("t1_credit15", int'(credit), 15);
        chk("t1_state_credit", int'(state), 1);
        sel();
        for (int i = 0; i < VEND_CYCLES; i++) begin
            chk("t1_vend_state", int'(state), 2);
            chk("t1_vend_dispense", int'(dispense), 1);
            chk("t1_vend_credit", int'(credit), 2);
            @(negedge clk);
        end
        chk("t1_change_state", int'(state), 3);
        chk("t1_dispense_off", int'(dispense), 0);
        count_pulses(8, pc);
        chk("t1_pulses", pc, 2);
        chk("t1_idle", int'(state), 0);
        chk("t1_credit0", int'(credit), 0);

        // Exact price: straight back to IDLE, no change
        put(2); put(2); put(2); put(2); put(5);
        chk("t2_credit13", int'(credit), 13);
        sel();
        for (int i = 0; i < VEND_CYCLES; i++) begin
            chk("t2_vend_dispense", int'(dispense), 1);
            @(negedge clk);
        end
        chk("t2_idle", int'(state), 0);
        count_pulses(6, pc);
        chk("t2_pulses", pc, 0);

        // Insufficient credit, then no stock, then refund
        put(2); put(2); put(2); put(2); put(2);
        sel();
        chk("t3_low_state", int'(state), 1);
        chk("t3_low_credit", int'(credit), 10);
        put(5);
        stock_empty = 1'b1;
        sel();
        stock_empty = 1'b0;
        chk("t3_empty_state", int'(state), 1);
        chk("t3_empty_credit", int'(credit), 15);
        do_cancel();
        chk("t3_refund_state", int'(state), 4);
        count_pulses(20, pc);
        chk("t3_pulses", pc, 15);
        chk("t3_idle", int'(state), 0);

        // Credit limit
        for (int i = 0; i < 7; i++) put(5);
        put(2); put(1);
        chk("t4_credit38", int'(credit), 38);
        put(5);
        chk("t4_q_reject", int'(coin_reject), 1);
        chk("t4_credit_still38", int'(credit), 38);
        put(2);
        chk("t4_credit40", int'(credit), 40);
        chk("t4_d_accept", int'(coin_reject), 0);
        put(1);
        chk("t4_n_reject", int'(coin_reject), 1);
        chk("t4_credit_still40", int'(credit), 40);
        do_cancel();
        wait_state(0, 60, "t4_wait_idle");

        // Simultaneous coins, coin during VEND, select+cancel together
        coin_n = 1'b1; coin_d = 1'b1;
        @(negedge clk);
        coin_n = 1'b0; coin_d = 1'b0;
        chk("t5_dual_reject", int'(coin_reject), 1);
        chk("t5_dual_credit", int'(credit), 0);
        chk("t5_dual_state", int'(state), 0);
        put(5); put(5); put(2); put(1);
        sel();
        put(5);
        chk("t5_vend_reject", int'(coin_reject), 1);
        chk("t5_vend_state", int'(state), 2);
        chk("t5_vend_credit", int'(credit), 0);
        wait_state(0, 20, "t5_wait_idle1");
        put(2);
        select = 1'b1; cancel = 1'b1;
        @(negedge clk);
        select = 1'b0; cancel = 1'b0;
        chk("t5_selcancel_refund", int'(state), 4);
        wait_state(0, 20, "t5_wait_idle2");

        // Asynchronous reset in the middle of CHANGE
        put(5); put(5); put(5); put(2);
        sel();
        wait_state(3, 20, "t6_reach_change");
        @(negedge clk);
        chk("t6_credit3", int'(credit), 3);
        chk("t6_pulse_on", int'(change_pulse), 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_state", int'(state), 0);
        chk("t6_async_credit", int'(credit), 0);
        chk("t6_async_pulse", int'(change_pulse), 0);
        chk("t6_async_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        put(1);
        chk("t6_resume_credit", int'(credit), 1);
        chk("t6_resume_state", int'(state), 1);

        // Randomized traffic, checked by the per-cycle model compare
        for (int c = 0; c < 3000; c++) begin
            int r;
            @(negedge clk);
            reset = 1'b0;
            r = $urandom_range(0, 99);
            coin_n = (r < 10) || (r >= 30 && r < 33);
            coin_d = (r >= 10 && r < 20) || (r >= 30 && r < 32);
            coin_q = (r >= 20 && r < 30) || (r == 32);
            select = ($urandom_range(0, 9) == 0);
            cancel = ($urandom_range(0, 39) == 0);
            stock_empty = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b1;
            end
        end
        @(negedge clk);
        reset = 1'b0;
        coin_n = 1'b0; coin_d = 1'b0; coin_q = 1'b0;
        select = 1'b0; cancel = 1'b0; stock_empty = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
